// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: digit width, largest legal
// digit, controller state encoding and the digit-validity helper.
// Pure declarations, no latency or flow control of its own.
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A nibble is a legal BCD digit when it lies in 0..9.
    function automatic logic is_bcd_digit(input logic [BCD_W-1:0] value);
        return value <= BCD_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_adder.sv
// One-digit BCD adder: sum = (a + b + cin) mod 10, cout = decimal carry.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
// Ports: a, b  - BCD digits in; cin - carry in;
//        sum   - BCD digit out; cout - decimal carry out.
module bcd_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    assign raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

    // Binary sums above 9 are brought back into the decimal range by adding
    // 6, which skips the six unused nibble codes A..F.
    always_comb begin
        sum  = raw[3:0];
        cout = 1'b0;
        if (raw > 5'd9) begin
            sum  = raw[3:0] + 4'd6;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Adds two N_DIGITS packed-BCD operands LSD first through one shared digit adder.
// Latency: done pulses N_DIGITS+1 cycles after the accepting start edge.
// No backpressure: start is accepted only in IDLE and dropped (not queued) otherwise.
// Ports: clk, rst (async, active-high); start request; a, b packed-BCD operands
//        (digit 0 in bits [3:0]); cin carry into digit 0; busy while digits run;
//        done one-cycle result strobe; sum, cout result; err invalid-digit flag.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [4*N_DIGITS-1:0]     a,
    input  logic [4*N_DIGITS-1:0]     b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [4*N_DIGITS-1:0]     sum,
    output logic                      cout,
    output logic                      err
);

    localparam int W     = BCD_W * N_DIGITS;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    state_e             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;
    logic               carry_q;
    logic               cout_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx_q;

    logic [BCD_W-1:0]   dig_a;
    logic [BCD_W-1:0]   dig_b;
    logic [BCD_W-1:0]   dig_sum;
    logic               dig_cout;
    logic               err_d;

    // Select the operand digits at the current index.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_a = a_q[i*BCD_W +: BCD_W];
                dig_b = b_q[i*BCD_W +: BCD_W];
            end
        end
    end

    // Invalid-digit check on the live inputs, captured on the accepting edge.
    always_comb begin
        err_d = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!is_bcd_digit(a[i*BCD_W +: BCD_W]) || !is_bcd_digit(b[i*BCD_W +: BCD_W])) begin
                err_d = 1'b1;
            end
        end
    end

    bcd_adder u_bcd_adder (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        err_q   <= err_d;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N_DIGITS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            sum_q[i*BCD_W +: BCD_W] <= dig_sum;
                        end
                    end
                    carry_q <= dig_cout;
                    if (idx_q == LAST_IDX) begin
                        // Index is left at the last digit; it is reloaded on the next start.
                        cout_q  <= dig_cout;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
module tb_bcd_serial_adder_ctrl;

    localparam int N = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   a;
    logic [15:0]   b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [15:0]   sum;
    logic          cout;
    logic          err;

    int vec_cnt;
    int miss_cnt;

    bcd_serial_adder_ctrl #(.N_DIGITS(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: start at an edge, then watch N+3 cycles sampled on negedges.
    // poke re-asserts start with other operands during RUN and during DONE.
    task automatic do_op(input string tag,
                         input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic [15:0] es, input logic ec, input logic ee,
                         input bit chk_sum, input bit poke);
        int bcnt;
        int dcnt;
        int done_k;
        logic [15:0] s_cap;
        logic        c_cap;
        logic        e_cap;
        bcnt   = 0;
        dcnt   = 0;
        done_k = 0;
        s_cap  = '0;
        c_cap  = 1'b0;
        e_cap  = 1'b0;
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        for (int k = 1; k <= N + 3; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                done_k = k;
                s_cap  = sum;
                c_cap  = cout;
                e_cap  = err;
            end
            if (k == 1) start = 1'b0;
            if (poke && k == 2) begin
                start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
            end
            if (poke && k == 3) start = 1'b0;
            if (poke && k == N + 1) begin
                start = 1'b1; a = 16'h4444; b = 16'h3333; cin = 1'b0;
            end
            if (poke && k == N + 2) start = 1'b0;
        end
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(N));
        chk({tag, "_done_pulses"}, 64'(dcnt), 64'd1);
        chk({tag, "_done_cycle"}, 64'(done_k), 64'(N + 1));
        chk({tag, "_err"}, 64'(e_cap), 64'(ee));
        if (chk_sum) begin
            chk({tag, "_sum"}, 64'(s_cap), 64'(es));
            chk({tag, "_cout"}, 64'(c_cap), 64'(ec));
            chk({tag, "_sum_hold"}, 64'(sum), 64'(es));
        end
    endtask

    initial begin
        int dcnt;
        vec_cnt  = 0;
        miss_cnt = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_err",  64'(err),  64'd0);
        rst = 1'b0;

        do_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("ripple_9999_1", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op("max_19999",     16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op("bad_digit",     16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op("err_clear",     16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("msd_carry",     16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op("ignored_start", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, 1'b1);
        do_op("after_ignore",  16'h0909, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset two cycles into RUN.
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_sum",  64'(sum),  64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        chk("midrst_err",  64'(err),  64'd0);
        dcnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst = 1'b0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_no_done", 64'(dcnt), 64'd0);

        do_op("post_rst_cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Sequential controller that adds two N-digit packed-BCD operands by time-sharing one single-digit BCD adder across all digit positions. It processes the least-significant digit first, one digit per clock, and keeps the inter-digit carry in a register. A start/busy/done handshake frames each operation. It sits between a register or bus front-end and the existing combinational one-digit BCD adder (a, b, cin -> sum, cout), so wide decimal sums are possible without replicating the adder.

Parameters:
N_DIGITS, 4, number of BCD digits per operand; legal range 1..16.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset; asynchronous, active-high.
start  input  1  request a new addition; sampled only in IDLE.
a  input  4*N_DIGITS  operand A, packed BCD; digit 0 = a[3:0] (LSD).
b  input  4*N_DIGITS  operand B, packed BCD, same packing as a.
cin  input  1  carry into digit 0.
busy  output  1  high while digits are being processed (RUN).
done  output  1  one-cycle pulse: sum/cout/err are valid.
sum  output  4*N_DIGITS  packed-BCD result, same packing as a.
cout  output  1  decimal carry out of the MSD.
err  output  1  high if any a or b digit was >9 at start.

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE; busy=0, done=0, sum=0, cout=0, err=0; internal carry, digit index and operand registers = 0. The operation in progress is abandoned and never signals done.
- FSM states:
  - IDLE: waits for start.
  - RUN: processes one digit per cycle.
  - DONE: single cycle, presents the result, then returns to IDLE.
- IDLE with start=1 at edge E0:
  - latch a and b into operand registers;
  - carry<=cin, idx<=0;
  - err<=OR over all 2*N_DIGITS digits of (digit>9);
  - state<=RUN.
  - start=0 leaves IDLE unchanged and all outputs hold.
- RUN, each edge:
  - the digit adder sees operand digit idx of A and B plus carry;
  - its sum is written to result digit idx; carry<=adder cout; idx<=idx+1;
  - on the edge that writes digit N_DIGITS-1: cout<=adder cout, state<=DONE.
- DONE: state<=IDLE on the next edge.
- Outputs are registered / decoded from state: busy=(state==RUN); done=(state==DONE).
- Timing: with start sampled at E0, busy is high for exactly N_DIGITS cycles after E0 and done is high in the cycle after edge E0+N_DIGITS. Latency from start to done = N_DIGITS+1 cycles. Minimum spacing between accepted starts = N_DIGITS+2 cycles.
- start is ignored in RUN and DONE; it is not queued. Operand inputs are don't-care outside the accepting edge.
- sum, cout and err may change during RUN. They are valid while done=1 and stay stable in IDLE until the next accepted start.
- Invalid digits: computation still runs. The value in sum is whatever the digit adder produces; err=1 flags that it is meaningless.
- Arithmetic: carry is 1 bit. The digit adder guarantees result digits 0..9 for valid inputs. The maximum sum of two valid digits plus carry is 19, so the carry never exceeds 1.
- Digit index width = max(1, clog2(N_DIGITS)). Wrap-around never occurs because the transition to DONE happens at idx==N_DIGITS-1. N_DIGITS=1 gives one RUN cycle.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W=4;
  - BCD_MAX=9;
  - the FSM state enum {IDLE, RUN, DONE};
  - a function is_bcd_digit(value) returning value<=9, used for err.
- One sub-module is natural: the existing one-digit bcd_adder, instantiated once and unmodified.
- The controller has no arithmetic of its own beyond the index counter and the digit-valid OR.

Test Plan:
- N_DIGITS=4, a=0x1234, b=0x5678, cin=0, pulse start -> busy high 4 cycles; done 5 cycles after the start edge; sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. The carry ripples through all four digits.
- a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1 (max case 19999).
- a=0x00A0, b=0x0000 -> err=1 at done; then a=0x0001, b=0x0002 -> sum=0x0003, err=0 (err cleared by the new start).
- Pulse start again during busy and during done with different operands -> no effect; the first result is unchanged and exactly one done pulse occurs. A following start accepted in IDLE computes the new operands.
- Assert rst two cycles into RUN -> busy, done, sum, cout, err all 0 immediately (asynchronously) and no done pulse; after release, a new start with 0x0000+0x0000, cin=1 -> sum=0x0001, cout=0.
